// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants used by the fetch path.
package riscv_pkg;

    localparam int unsigned DEFAULT_ADDR_W   = 64;
    localparam int unsigned DEFAULT_INST_W   = 32;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
    localparam int unsigned PC_INCR          = 4;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers, async active-low reset and a flush input.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_flush && o_full && !i_pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: request/response instruction memory port, prefetch FIFO and branch redirect.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned        ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned        INST_W     = DEFAULT_INST_W,
    parameter int unsigned        FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [INST_W-1:0] mem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0]        r_fetch_pc;
    logic [CW-1:0]            r_discard;

    logic                     w_accept;
    logic [CW-1:0]            w_inflight;
    logic [CW-1:0]            w_inflight_next;
    logic [CW:0]              w_occupancy;
    logic                     w_drop;
    logic                     w_pf_push;
    logic                     w_pf_pop;
    logic                     w_pf_full;
    logic                     w_pf_empty;
    logic [CW-1:0]            w_pf_count;
    logic [INST_W+ADDR_W-1:0] w_pf_head;
    logic [ADDR_W-1:0]        w_rq_pc;
    logic                     w_rq_full;
    logic                     w_rq_empty;

    // Outstanding requests are exactly the occupancy of the request-PC FIFO.
    assign w_occupancy     = {1'b0, w_inflight} + {1'b0, w_pf_count};
    assign mem_req_valid   = reset && !redirect_valid &&
                             (w_occupancy < (CW+1)'(FIFO_DEPTH));
    assign mem_req_addr    = r_fetch_pc;
    assign w_accept        = mem_req_valid && mem_req_ready;
    assign w_inflight_next = w_inflight + CW'(w_accept) - CW'(mem_resp_valid);

    assign w_drop    = redirect_valid || (r_discard != '0);
    assign w_pf_push = mem_resp_valid && !w_drop;
    assign w_pf_pop  = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid = !w_pf_empty;
    assign {inst_out, inst_pc} = inst_valid ? w_pf_head : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc & ~ADDR_W'(3);
        end else if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_INCR);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_discard <= '0;
        end else if (redirect_valid) begin
            r_discard <= w_inflight_next;
        end else if (mem_resp_valid && (r_discard != '0)) begin
            r_discard <= r_discard - CW'(1);
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_pc_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_flush (1'b0),
        .i_push  (w_accept),
        .i_data  (r_fetch_pc),
        .i_pop   (mem_resp_valid),
        .o_data  (w_rq_pc),
        .o_full  (w_rq_full),
        .o_empty (w_rq_empty),
        .o_count (w_inflight)
    );

    sync_fifo #(
        .WIDTH (INST_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_flush (redirect_valid),
        .i_push  (w_pf_push),
        .i_data  ({mem_resp_data, w_rq_pc}),
        .i_pop   (w_pf_pop),
        .o_data  (w_pf_head),
        .o_full  (w_pf_full),
        .o_empty (w_pf_empty),
        .o_count (w_pf_count)
    );

    a_resp_has_request: assert property (@(posedge clk) disable iff (!reset)
        !(mem_resp_valid && w_rq_empty));
    a_accept_has_slot: assert property (@(posedge clk) disable iff (!reset)
        !(w_accept && w_rq_full));
    a_full_means_idle: assert property (@(posedge clk) disable iff (!reset)
        !(w_pf_full && (w_inflight != '0)));

endmodule
